// File: rtl/sdram_responder.sv
// sdram_responder
// Host-side stand-in for the SDRAM controller. It answers the valid/ready
// request bus with an on-chip word array and applies programmable start-up
// delay and access latencies, so bridge and sequencer logic can be brought
// up without the SDRAM device or its controller.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   reset      in   synchronous active-high reset
//   addr       in   byte address (bits [1:0] ignored, high bits wrap)
//   din        in   write data
//   wmask      in   byte-lane write enables, all zero means read
//   valid      in   request, held until ready is seen
//   dout       out  read data, changes only when a read completes
//   ready      out  one-cycle completion pulse
//   busy       out  low only while idle and able to accept
//   init_done  out  high once the start-up delay has elapsed
module sdram_responder #(
    parameter int unsigned ADDR_WIDTH    = 25,
    parameter int unsigned MEM_WORDS     = 1024,
    parameter int unsigned INIT_CYCLES   = 16,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    input  logic [3:0]            wmask,
    input  logic                  valid,
    output logic [31:0]           dout,
    output logic                  ready,
    output logic                  busy,
    output logic                  init_done
);

    localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
    localparam int unsigned LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_MAX = (INIT_CYCLES > LAT_MAX) ? INIT_CYCLES : LAT_MAX;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               accept_c;
    logic               commit_c;

    // Request captured at the accept edge; later input changes are ignored
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        din_q;
    logic [3:0]         wmask_q;
    logic               is_write_q;

    logic [31:0]        mem [MEM_WORDS];

    // Byte offset and bits above the array size do not select anything
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{addr[1:0], addr[ADDR_WIDTH-1:IDX_W+2]};

    // Next-state and counter logic
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        case (state)
            ST_INIT: begin
                if (cnt == CNT_W'(0)) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (valid) begin
                    accept_c   = 1'b1;
                    state_next = ST_ACCESS;
                    cnt_next   = (|wmask) ? CNT_W'(WRITE_LATENCY - 1)
                                          : CNT_W'(READ_LATENCY - 1);
                end
            end
            ST_ACCESS: begin
                if (cnt == CNT_W'(0)) begin
                    state_next = ST_DONE;
                    commit_c   = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // State, request latches and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_INIT;
            cnt        <= CNT_W'(INIT_CYCLES - 1);
            idx_q      <= '0;
            din_q      <= '0;
            wmask_q    <= '0;
            is_write_q <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
            dout       <= 32'h0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= (state_next == ST_DONE);
            busy  <= (state_next != ST_IDLE);
            if (state == ST_INIT && state_next == ST_IDLE) begin
                init_done <= 1'b1;
            end
            if (accept_c) begin
                idx_q      <= addr[2 +: IDX_W];
                din_q      <= din;
                wmask_q    <= wmask;
                is_write_q <= |wmask;
            end
            // Read data lands on the same edge the access finishes
            if (commit_c && !is_write_q) begin
                dout <= mem[idx_q];
            end
        end
    end

    // Backing array is never cleared; a reset before commit drops the write
    always_ff @(posedge clk) begin
        if (!reset && commit_c && is_write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= din_q[8*i +: 8];
                end
            end
        end
    end

endmodule
